// File: rtl/control_sequencer.sv
// Multicycle MIPS control sequencer: fetch/decode/execute FSM whose state number
// indexes the datapath control ROM, with memory wait states, bus timeout and illegal-opcode trap.
module control_sequencer #(
    parameter int STATE_W     = 7,
    parameter int MOC_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instruction,
    input  logic               moc,
    input  logic               cond,
    output logic [STATE_W-1:0] state,
    output logic               mov,
    output logic               mem_rw,
    output logic               ir_ld,
    output logic               pc_ld,
    output logic               rf_ld,
    output logic               illegal_op,
    output logic               bus_err
);

    // Memory handshake: mov is held high for the whole of a wait state; the transfer
    // completes on the rising edge where mov && moc. moc is ignored in every other state.

    typedef enum logic [4:0] {
        S_RESET      = 5'd0,
        S_FETCH      = 5'd1,
        S_FETCH_WAIT = 5'd2,
        S_IR_LOAD    = 5'd3,
        S_DECODE     = 5'd4,
        S_ILLEGAL    = 5'd5,
        S_ALU_ADDU   = 5'd6,
        S_STORE_ADDR = 5'd7,
        S_STORE_WAIT = 5'd8,
        S_BUS_ERR    = 5'd9,
        S_BEQ        = 5'd11,
        S_BRANCH     = 5'd12,
        S_LOAD_ADDR  = 5'd13,
        S_LOAD_WAIT  = 5'd14,
        S_LOAD_WB    = 5'd15,
        S_ALU_SUBU   = 5'd17,
        S_ALU_ADDIU  = 5'd18,
        S_ALU_SLTU   = 5'd19,
        S_ALU_SLTIU  = 5'd20,
        S_ALU_CLO    = 5'd21,
        S_ALU_CLZ    = 5'd22,
        S_ALU_AND    = 5'd23,
        S_ALU_ANDI   = 5'd24
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MOC_TIMEOUT - 1);

    state_t      state_q, state_d, dispatch;
    logic [7:0]  moc_cnt;
    logic        in_wait;
    logic        timeout_hit;
    logic [5:0]  opcode, funct;
    logic        unused_instr_bits;

    assign opcode            = instruction[31:26];
    assign funct             = instruction[5:0];
    // Register/immediate fields are consumed by the datapath, not by sequencing.
    assign unused_instr_bits = ^instruction[25:6];

    assign in_wait     = (state_q == S_FETCH_WAIT) || (state_q == S_STORE_WAIT) ||
                         (state_q == S_LOAD_WAIT);
    assign timeout_hit = (moc_cnt == TIMEOUT_LAST);

    always_comb begin
        dispatch = S_ILLEGAL;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h21:   dispatch = S_ALU_ADDU;
                    6'h23:   dispatch = S_ALU_SUBU;
                    6'h2B:   dispatch = S_ALU_SLTU;
                    6'h24:   dispatch = S_ALU_AND;
                    default: dispatch = S_ILLEGAL;
                endcase
            end
            6'h1C: begin
                case (funct)
                    6'h21:   dispatch = S_ALU_CLO;
                    6'h20:   dispatch = S_ALU_CLZ;
                    default: dispatch = S_ILLEGAL;
                endcase
            end
            6'h09:                      dispatch = S_ALU_ADDIU;
            6'h0B:                      dispatch = S_ALU_SLTIU;
            6'h0C:                      dispatch = S_ALU_ANDI;
            6'h28, 6'h29, 6'h2B:        dispatch = S_STORE_ADDR;
            6'h04:                      dispatch = S_BEQ;
            6'h23, 6'h21, 6'h25,
            6'h20, 6'h24:               dispatch = S_LOAD_ADDR;
            default:                    dispatch = S_ILLEGAL;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:      state_d = S_FETCH;
            S_FETCH:      state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                if (moc)              state_d = S_IR_LOAD;
                else if (timeout_hit) state_d = S_BUS_ERR;
            end
            S_IR_LOAD:    state_d = S_DECODE;
            S_DECODE:     state_d = dispatch;
            S_STORE_ADDR: state_d = S_STORE_WAIT;
            S_STORE_WAIT: begin
                if (moc)              state_d = S_FETCH;
                else if (timeout_hit) state_d = S_BUS_ERR;
            end
            S_BEQ:        state_d = cond ? S_BRANCH : S_FETCH;
            S_BRANCH:     state_d = S_FETCH;
            S_LOAD_ADDR:  state_d = S_LOAD_WAIT;
            S_LOAD_WAIT: begin
                if (moc)              state_d = S_LOAD_WB;
                else if (timeout_hit) state_d = S_BUS_ERR;
            end
            S_LOAD_WB:    state_d = S_FETCH;
            S_ILLEGAL:    state_d = S_FETCH;
            S_BUS_ERR:    state_d = S_BUS_ERR;
            S_ALU_ADDU, S_ALU_SUBU, S_ALU_ADDIU, S_ALU_SLTU,
            S_ALU_SLTIU, S_ALU_CLO, S_ALU_CLZ, S_ALU_AND,
            S_ALU_ANDI:   state_d = S_FETCH;
            default:      state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_RESET;
        else       state_q <= state_d;
    end

    // Counter idles at zero outside wait states, so every wait state is entered with it cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        moc_cnt <= 8'd0;
        else if (!in_wait) moc_cnt <= 8'd0;
        else if (!moc)     moc_cnt <= moc_cnt + 8'd1;
    end

    always_comb begin
        mov        = 1'b0;
        mem_rw     = 1'b1;
        ir_ld      = 1'b0;
        pc_ld      = 1'b0;
        rf_ld      = 1'b0;
        illegal_op = 1'b0;
        bus_err    = 1'b0;
        case (state_q)
            S_FETCH_WAIT, S_LOAD_WAIT: mov = 1'b1;
            S_STORE_ADDR:              mem_rw = 1'b0;
            S_STORE_WAIT: begin
                mov    = 1'b1;
                mem_rw = 1'b0;
            end
            S_IR_LOAD:                 ir_ld = 1'b1;
            S_BRANCH:                  pc_ld = 1'b1;
            S_ILLEGAL:                 illegal_op = 1'b1;
            S_BUS_ERR:                 bus_err = 1'b1;
            S_LOAD_WB, S_ALU_ADDU, S_ALU_SUBU, S_ALU_ADDIU, S_ALU_SLTU,
            S_ALU_SLTIU, S_ALU_CLO, S_ALU_CLZ, S_ALU_AND,
            S_ALU_ANDI:                rf_ld = 1'b1;
            default: ;
        endcase
    end

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: a per-instruction reference model pushes the
// expected state/output word for each cycle; a negedge monitor pops and compares.
module tb_control_sequencer;

    localparam int STATE_W     = 7;
    localparam int MOC_TIMEOUT = 15;
    localparam int W           = STATE_W + 7;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               moc = 1'b0;
    logic               cond = 1'b0;
    logic [31:0]        instruction = 32'd0;
    logic [STATE_W-1:0] state;
    logic               mov, mem_rw, ir_ld, pc_ld, rf_ld, illegal_op, bus_err;

    control_sequencer #(.STATE_W(STATE_W), .MOC_TIMEOUT(MOC_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .moc(moc), .cond(cond),
        .state(state), .mov(mov), .mem_rw(mem_rw), .ir_ld(ir_ld), .pc_ld(pc_ld),
        .rf_ld(rf_ld), .illegal_op(illegal_op), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    logic [31:0]  cur_instr = 32'd0;
    int           tests = 0;
    int           fails = 0;

    wire [W-1:0] act_word = {state, mov, mem_rw, ir_ld, pc_ld, rf_ld, illegal_op, bus_err};

    // Decode rules as lookup tables: {opcode or funct, target state}.
    int r_tab  [4][2]  = '{'{'h21, 6}, '{'h23, 17}, '{'h2B, 19}, '{'h24, 23}};
    int sp_tab [2][2]  = '{'{'h21, 21}, '{'h20, 22}};
    int i_tab  [12][2] = '{'{'h09, 18}, '{'h0B, 20}, '{'h0C, 24}, '{'h28, 7}, '{'h29, 7},
                           '{'h2B, 7}, '{'h04, 11}, '{'h23, 13}, '{'h21, 13}, '{'h25, 13},
                           '{'h20, 13}, '{'h24, 13}};

    function automatic int target_of(input logic [31:0] ins);
        int op, fn, t;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        t  = 5;
        for (int i = 0; i < 4; i++)  if (op == 0 && fn == r_tab[i][0])     t = r_tab[i][1];
        for (int i = 0; i < 2; i++)  if (op == 'h1C && fn == sp_tab[i][0]) t = sp_tab[i][1];
        for (int i = 0; i < 12; i++) if (op == i_tab[i][0])                t = i_tab[i][1];
        return t;
    endfunction

    function automatic logic [W-1:0] exp_word(input int s);
        logic mv, rw, ir, pc, rf, il, be;
        mv = (s == 2) || (s == 8) || (s == 14);
        rw = !((s == 7) || (s == 8));
        ir = (s == 3);
        pc = (s == 12);
        rf = (s == 6) || (s == 15) || (s >= 17 && s <= 24);
        il = (s == 5);
        be = (s == 9);
        return {STATE_W'(s), mv, rw, ir, pc, rf, il, be};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            tests++;
            if (act_word !== mon_exp) begin
                fails++;
                $display("FAIL cycle t=%0t: state=%0d outs=%b, required state=%0d outs=%b",
                         $time, act_word[W-1:7], act_word[6:0], mon_exp[W-1:7], mon_exp[6:0]);
            end
        end
    end

    // One cycle: inputs for the cycle in which the DUT is expected to sit in state s.
    task automatic step(input int s, input logic m, input logic c);
        @(posedge clk);
        #1;
        moc         = m;
        cond        = c;
        instruction = (s == 4) ? cur_instr : $urandom();
        exp_q.push_back(exp_word(s));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if (act_word !== exp_word(0)) begin
            fails++;
            $display("FAIL async_reset t=%0t: state=%0d outs=%b, required state=0 outs=%b",
                     $time, act_word[W-1:7], act_word[6:0], exp_word(0) & 7'h7F);
        end
        @(posedge clk);
        #1;
        moc = rb();
        exp_q.push_back(exp_word(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        moc   = rb();
        exp_q.push_back(exp_word(0));
    endtask

    task automatic wait_phase(input int w, input int stalls, output bit timed_out);
        timed_out = 1'b0;
        for (int i = 0; i < stalls; i++) begin
            step(w, 1'b0, rb());
            if (i == MOC_TIMEOUT - 1) begin
                timed_out = 1'b1;
                break;
            end
        end
        if (timed_out) begin
            for (int k = 0; k < 4; k++) step(9, rb(), rb());
            do_reset();
        end else begin
            step(w, 1'b1, rb());
        end
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic c, input int fs, input int ms,
                             input bit reset_mid);
        bit to;
        int tgt;
        cur_instr = ins;
        tgt       = target_of(ins);
        step(1, rb(), rb());
        wait_phase(2, fs, to);
        if (to) return;
        step(3, rb(), rb());
        step(4, rb(), rb());
        if (tgt == 5) begin
            step(5, rb(), rb());
        end else if (tgt == 7) begin
            step(7, rb(), rb());
            wait_phase(8, ms, to);
        end else if (tgt == 11) begin
            step(11, rb(), c);
            if (c) step(12, rb(), rb());
        end else if (tgt == 13) begin
            step(13, rb(), rb());
            if (reset_mid) begin
                step(14, 1'b0, rb());
                step(14, 1'b0, rb());
                do_reset();
                return;
            end
            wait_phase(14, ms, to);
            if (!to) step(15, rb(), rb());
        end else begin
            step(tgt, rb(), rb());
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] ins;
        int k;
        ins = $urandom();
        k   = $urandom_range(0, 18);
        if (k < 4) begin
            ins[31:26] = 6'h00;
            ins[5:0]   = 6'(r_tab[k][0]);
        end else if (k < 6) begin
            ins[31:26] = 6'h1C;
            ins[5:0]   = 6'(sp_tab[k-4][0]);
        end else if (k < 18) begin
            ins[31:26] = 6'(i_tab[k-6][0]);
        end
        return ins;
    endfunction

    function automatic int pick_stalls();
        int r;
        r = $urandom_range(0, 39);
        if (r < 34)      return $urandom_range(0, 3);
        else if (r < 39) return MOC_TIMEOUT - 1;
        else             return MOC_TIMEOUT;
    endfunction

    initial begin
        do_reset();
        run_instr(32'h00221821, 1'b0, 0, 0, 1'b0);   // ADDU
        run_instr(32'h8C220004, 1'b0, 0, 3, 1'b0);   // LW, 3 stall cycles
        run_instr(32'h10220003, 1'b1, 0, 0, 1'b0);   // BEQ taken
        run_instr(32'h10220003, 1'b0, 0, 0, 1'b0);   // BEQ not taken
        run_instr(32'hFC000000, 1'b0, 0, 0, 1'b0);   // illegal
        run_instr(32'hAC220004, 1'b0, 0, MOC_TIMEOUT - 1, 1'b0);  // moc on last allowed cycle
        run_instr(32'hAC220004, 1'b0, 0, MOC_TIMEOUT, 1'b0);      // store timeout
        run_instr(32'h00221821, 1'b0, 1, 0, 1'b0);
        run_instr(32'h8C220004, 1'b0, 0, 0, 1'b1);   // reset mid load wait
        run_instr(32'h00000000, 1'b0, 0, 0, 1'b0);   // SLL: R-type funct not decoded
        for (int n = 0; n < 80; n++) begin
            run_instr(gen_instr(), rb(), pick_stalls(), pick_stalls(),
                      ($urandom_range(0, 24) == 0));
        end
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
